// File: rtl/cpu_step_ctrl.sv
// Turns the 1 Hz divider output and two debounced buttons into a one-cycle CPU clock enable.
// cpu_en is registered one cycle after the qualifying tick/press; events are never queued.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk_50Mhz,
  input  logic        reset,
  input  logic        clk_1hz,
  input  logic        btn_mode,
  input  logic        btn_step,
  output logic        cpu_en,
  output logic        mode_run,
  output logic [15:0] step_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_cpu_en;
  logic        w_cpu_en_nxt;
  logic [15:0] r_step_count;

  logic        r_1hz_s1;
  logic        r_1hz_s2;
  logic        r_1hz_d;
  logic [1:0]  r_1hz_vld;
  logic        r_1hz_arm;
  logic        w_tick;

  // Bit 0 is the mode button, bit 1 the step button.
  logic [1:0]      w_btn_raw;
  logic [1:0]      r_btn_s1;
  logic [1:0]      r_btn_s2;
  logic [1:0]      r_btn_stable;
  logic [1:0]      r_btn_stable_d;
  logic [DB_W-1:0] r_db_cnt [2];
  logic [1:0]      w_press;

  assign w_btn_raw = {btn_step, btn_mode};

  // The arm flag needs one real low sample first, so a clk_1hz already high at reset release is not a tick.
  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      r_1hz_s1  <= 1'b0;
      r_1hz_s2  <= 1'b0;
      r_1hz_d   <= 1'b0;
      r_1hz_vld <= 2'b00;
      r_1hz_arm <= 1'b0;
    end else begin
      r_1hz_s1  <= clk_1hz;
      r_1hz_s2  <= r_1hz_s1;
      r_1hz_d   <= r_1hz_s2;
      r_1hz_vld <= {r_1hz_vld[0], 1'b1};
      r_1hz_arm <= r_1hz_arm | (r_1hz_vld[1] & ~r_1hz_s2);
    end
  end

  assign w_tick = r_1hz_s2 & ~r_1hz_d & r_1hz_arm;

  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      r_btn_s1       <= 2'b00;
      r_btn_s2       <= 2'b00;
      r_btn_stable   <= 2'b00;
      r_btn_stable_d <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_btn_s1       <= w_btn_raw;
      r_btn_s2       <= r_btn_s1;
      r_btn_stable_d <= r_btn_stable;
      for (int i = 0; i < 2; i++) begin
        if (r_btn_s2[i] != r_btn_stable[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_btn_stable[i] <= r_btn_s2[i];
            r_db_cnt[i]     <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_press = r_btn_stable & ~r_btn_stable_d;

  // A mode press outranks a tick or step press arriving in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cpu_en_nxt = 1'b0;
    case (r_state)
      ST_PAUSE: begin
        if (w_press[0]) begin
          w_state_nxt = ST_RUN;
        end else if (w_press[1]) begin
          w_cpu_en_nxt = ~r_cpu_en;
        end
      end
      ST_RUN: begin
        if (w_press[0]) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_tick) begin
          w_cpu_en_nxt = ~r_cpu_en;
        end
      end
      default: begin
        w_state_nxt = ST_PAUSE;
      end
    endcase
  end

  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      r_state      <= ST_PAUSE;
      r_cpu_en     <= 1'b0;
      r_step_count <= 16'h0000;
    end else begin
      r_state  <= w_state_nxt;
      r_cpu_en <= w_cpu_en_nxt;
      if (w_cpu_en_nxt) begin
        r_step_count <= r_step_count + 16'h0001;
      end
    end
  end

  assign cpu_en     = r_cpu_en;
  assign mode_run   = (r_state == ST_RUN);
  assign step_count = r_step_count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: an event-level model predicts each enable pulse (edge and count),
// a monitor pops predictions whenever cpu_en is seen high and tracks mode_run/step_count every cycle.
module tb_cpu_step_ctrl;
  localparam int D        = 4;
  localparam int LAT_BTN  = D + 3;
  localparam int LAT_TICK = 3;
  localparam int NEV      = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_1hz;
  logic        btn_mode;
  logic        btn_step;
  logic        cpu_en;
  logic        mode_run;
  logic [15:0] step_count;

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_50Mhz  (clk),
    .reset      (reset),
    .clk_1hz    (clk_1hz),
    .btn_mode   (btn_mode),
    .btn_step   (btn_step),
    .cpu_en     (cpu_en),
    .mode_run   (mode_run),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          edge_n = 0;
  bit          ev_mode [NEV];
  bit          ev_step [NEV];
  bit          ev_tick [NEV];
  logic        m_mode  = 1'b0;
  logic [15:0] m_count = 16'h0000;
  int          total   = 0;
  int          bad     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, req, edge_n);
    end
  endtask

  // Reference model: each posedge consumes the button/tick events the stimulus scheduled for it.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
        m_mode  = 1'b0;
        m_count = 16'h0000;
        for (int i = edge_n; i < edge_n + 64 && i < NEV; i++) begin
          ev_mode[i] = 1'b0;
          ev_step[i] = 1'b0;
          ev_tick[i] = 1'b0;
        end
      end else if (edge_n < NEV) begin
        if (ev_mode[edge_n]) begin
          m_mode = ~m_mode;
        end else if ((m_mode && ev_tick[edge_n]) || (!m_mode && ev_step[edge_n])) begin
          m_count = m_count + 16'h0001;
          exp_q.push_back('{t: edge_n, cnt: m_count});
        end
      end
    end
  end

  initial begin
    exp_t e;
    logic prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_en === 1'b1) begin
        check("back_to_back_pulse", {31'd0, prev_en}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          if (bad <= 40) $display("FAIL unexpected_pulse: cpu_en high at edge %0d step_count=%0h, none predicted", edge_n, step_count);
        end else begin
          e = exp_q.pop_front();
          check("pulse_edge", edge_n, e.t);
          check("pulse_count", {16'd0, step_count}, {16'd0, e.cnt});
        end
      end
      check("mode_run_track", {31'd0, mode_run}, {31'd0, m_mode});
      check("step_count_track", {16'd0, step_count}, {16'd0, m_count});
      prev_en = cpu_en;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit is_mode, input int hold);
    int t0;
    t0 = edge_n;
    if (is_mode) btn_mode = 1'b1;
    else         btn_step = 1'b1;
    if (hold >= D && t0 + LAT_BTN < NEV) begin
      if (is_mode) ev_mode[t0 + LAT_BTN] = 1'b1;
      else         ev_step[t0 + LAT_BTN] = 1'b1;
    end
    wait_cyc(hold);
    if (is_mode) btn_mode = 1'b0;
    else         btn_step = 1'b0;
    wait_cyc(D + 4);
  endtask

  task automatic tick1hz(input int hi, input int lo);
    clk_1hz = 1'b1;
    if (edge_n + LAT_TICK < NEV) ev_tick[edge_n + LAT_TICK] = 1'b1;
    wait_cyc(hi);
    clk_1hz = 1'b0;
    wait_cyc(lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    reset    = 1'b1;
    clk_1hz  = 1'b0;
    btn_mode = 1'b0;
    btn_step = 1'b0;
    wait_cyc(3);
    check("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("reset_mode_run", {31'd0, mode_run}, 32'd0);
    check("reset_step_count", {16'd0, step_count}, 32'd0);
    reset = 1'b0;
    wait_cyc(5);

    // Ticks in PAUSE do nothing.
    repeat (3) tick1hz(3, 4);
    check("pause_ticks_count", {16'd0, step_count}, 32'd0);
    check("pause_ticks_mode", {31'd0, mode_run}, 32'd0);

    // One long step press, then a sub-threshold glitch.
    press(1'b0, 10);
    check("step_press_count", {16'd0, step_count}, 32'd1);
    press(1'b0, D - 1);
    check("step_glitch_count", {16'd0, step_count}, 32'd1);

    // Enter RUN; ticks issue pulses while step presses are ignored.
    press(1'b1, 6);
    check("enter_run", {31'd0, mode_run}, 32'd1);
    fork
      repeat (5) tick1hz(5, 7);
      repeat (3) press(1'b0, D + 1);
    join
    check("run_ticks_count", {16'd0, step_count}, 32'd6);
    check("run_mode_held", {31'd0, mode_run}, 32'd1);

    // Mode press lands on the same cycle as a tick: mode wins, no pulse.
    fork
      press(1'b1, 6);
      begin
        wait_cyc(D);
        tick1hz(4, 4);
      end
    join
    wait_cyc(4);
    check("collide_mode", {31'd0, mode_run}, 32'd0);
    check("collide_count", {16'd0, step_count}, 32'd6);

    // Preload the counter and wrap it with one step.
    force dut.r_step_count = 16'hFFFF;
    m_count = 16'hFFFF;
    wait_cyc(2);
    release dut.r_step_count;
    wait_cyc(2);
    check("preload_count", {16'd0, step_count}, 32'h0000FFFF);
    press(1'b0, 6);
    check("wrap_count", {16'd0, step_count}, 32'd0);

    // Reset in the middle of a step debounce, with the block in RUN and a nonzero count.
    press(1'b0, 6);
    press(1'b1, 6);
    t0 = edge_n;
    btn_step = 1'b1;
    wait_cyc(4);
    reset = 1'b1;
    wait_cyc(1);
    check("midreset_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("midreset_mode_run", {31'd0, mode_run}, 32'd0);
    check("midreset_step_count", {16'd0, step_count}, 32'd0);
    reset = 1'b0;
    if (edge_n + LAT_BTN < NEV) ev_step[edge_n + LAT_BTN] = 1'b1;
    wait_cyc(3);
    check("midreset_no_early_pulse", {16'd0, step_count}, 32'd0);
    wait_cyc(5);
    btn_step = 1'b0;
    wait_cyc(D + 4);
    check("midreset_fresh_press", {16'd0, step_count}, 32'd1);
    check("midreset_gap", edge_n - t0, 21);

    // Randomized mix of presses, glitches, ticks and idle time.
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 5))
        0: press(1'b1, $urandom_range(D, D + 4));
        1: press(1'b0, $urandom_range(D, D + 6));
        2: press(1'b0, $urandom_range(1, D - 1));
        3: tick1hz($urandom_range(2, 6), $urandom_range(3, 8));
        4: press(1'b1, $urandom_range(1, D - 1));
        default: wait_cyc($urandom_range(1, 5));
      endcase
    end

    wait_cyc(20);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
